// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared register-file widths and the writeback entry type
package pipeline_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wr;
    logic [REG_DATA_W-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if: writeback enqueue, register-file drain and decode lookup signals; RF_WQ_FWD_EN adds fwd1/fwd2
interface rf_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wr;
  logic [DATA_W-1:0] in_wd;
  logic              drain_en;
  logic              write;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] PR1;
  logic [ADDR_W-1:0] PR2;
  logic              hit1;
  logic              hit2;
  logic [$clog2(DEPTH):0] count;
`ifdef RF_WQ_FWD_EN
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  modport master (output in_valid, in_wr, in_wd, drain_en, PR1, PR2,
                  input in_ready, write, WR, WD, hit1, hit2, count, fwd1, fwd2);
  modport slave  (input in_valid, in_wr, in_wd, drain_en, PR1, PR2,
                  output in_ready, write, WR, WD, hit1, hit2, count, fwd1, fwd2);
`else
  modport master (output in_valid, in_wr, in_wd, drain_en, PR1, PR2,
                  input in_ready, write, WR, WD, hit1, hit2, count);
  modport slave  (input in_valid, in_wr, in_wd, drain_en, PR1, PR2,
                  output in_ready, write, WR, WD, hit1, hit2, count);
`endif
endinterface

// File: rtl/rf_wq_match.sv
// rf_wq_match: pending-write lookup for one read port; RF_WQ_FWD_EN returns the youngest matching data
module rf_wq_match #(
  parameter int DEPTH  = 4,
`ifdef RF_WQ_FWD_EN
  parameter int DATA_W = 32,
`endif
  parameter int ADDR_W = 5
) (
  input  logic [DEPTH-1:0]          valid,
  input  logic [ADDR_W-1:0]         wr [DEPTH],
`ifdef RF_WQ_FWD_EN
  input  logic [DATA_W-1:0]         wd [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head,
  output logic [DATA_W-1:0]         fwd,
`endif
  input  logic [ADDR_W-1:0]         pr,
  output logic                      hit
);
  localparam int IW = $clog2(DEPTH);
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (valid[i] && wr[i] == pr && pr != '0);
  end
`ifdef RF_WQ_FWD_EN
  // Valid entries are contiguous from head, so the last match in head order is the youngest.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < DEPTH; i++)
      fwd = (valid[head + IW'(i)] && wr[head + IW'(i)] == pr && pr != '0) ? wd[head + IW'(i)] : fwd;
  end
`endif
endmodule

// File: rtl/rf_write_queue.sv
// rf_write_queue: register-file writeback FIFO with RAW lookup; RF_WQ_FWD_EN adds youngest-match forwarding
module rf_write_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter bit DROP_R0 = 1'b1
) (
  input logic            clk,
  input logic            rst,
  rf_write_queue_if.slave q
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] wr_q [DEPTH];
  logic [ADDR_W-1:0] wr_d [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];
  logic [DATA_W-1:0] wd_d [DEPTH];
  logic [IW-1:0]     hidx, tidx;
  logic              full, empty, push, pop, h1, h2;
  always_comb begin
    hidx = head_q[IW-1:0];
    tidx = tail_q[IW-1:0];
    empty = head_q == tail_q;
    full = hidx == tidx && head_q[IW] != tail_q[IW];
    pop = !empty && q.drain_en && !rst;
    push = q.in_valid && !full && !(DROP_R0 && q.in_wr == '0);
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    valid_d = valid_q;
    wr_d = wr_q;
    wd_d = wd_q;
    if (pop) valid_d[hidx] = 1'b0;
    if (push) begin
      valid_d[tidx] = 1'b1;
      wr_d[tidx] = q.in_wr;
      wd_d[tidx] = q.in_wd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end
  assign q.in_ready = !full;
  assign q.write    = pop;
  assign q.WR       = pop ? wr_q[hidx] : '0;
  assign q.WD       = pop ? wd_q[hidx] : '0;
  assign q.count    = tail_q - head_q;
  assign q.hit1     = h1;
  assign q.hit2     = h2;
`ifdef RF_WQ_FWD_EN
  logic [DATA_W-1:0] f1, f2;
  assign q.fwd1 = f1;
  assign q.fwd2 = f2;
`endif
  rf_wq_match #(
    .DEPTH(DEPTH),
`ifdef RF_WQ_FWD_EN
    .DATA_W(DATA_W),
`endif
    .ADDR_W(ADDR_W)
  ) u_match1 (
    .valid(valid_q),
    .wr(wr_q),
`ifdef RF_WQ_FWD_EN
    .wd(wd_q),
    .head(hidx),
    .fwd(f1),
`endif
    .pr(q.PR1),
    .hit(h1)
  );
  rf_wq_match #(
    .DEPTH(DEPTH),
`ifdef RF_WQ_FWD_EN
    .DATA_W(DATA_W),
`endif
    .ADDR_W(ADDR_W)
  ) u_match2 (
    .valid(valid_q),
    .wr(wr_q),
`ifdef RF_WQ_FWD_EN
    .wd(wd_q),
    .head(hidx),
    .fwd(f2),
`endif
    .pr(q.PR2),
    .hit(h2)
  );
endmodule
